// File: rtl/fetch_stage_if.sv
// Instruction-memory port between the IF stage (master) and the memory (slave).
// One request is outstanding at a time; completion is a single-cycle resp pulse.
interface fetch_stage_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_rdata,
    input  imem_resp
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_rdata,
    output imem_resp
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage rv32i pipeline: owns the PC, issues imem reads and
// loads the IF/ID register while absorbing wait states, stalls and redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0060,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pcmux_sel,
  input  logic [31:0]          alu_out,
  input  logic                 stall,
  fetch_stage_if.master        imem,
  output logic                 ifid_valid,
  output logic [31:0]          ifid_pc,
  output logic [31:0]          ifid_instr
);

  localparam logic PCMUX_ALU_OUT = 1'b1;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic [31:0] hold_buf_r;
  logic [31:0] hold_buf_nxt_s;
  logic [31:0] redir_pc_r;
  logic [31:0] redir_pc_nxt_s;
  logic        ifid_valid_nxt_s;
  logic [31:0] ifid_pc_nxt_s;
  logic [31:0] ifid_instr_nxt_s;
  logic        redirect_s;

  assign redirect_s        = (pcmux_sel == PCMUX_ALU_OUT);
  // A read stays pending until resp, so the address is simply the PC register.
  assign imem.imem_read    = ~rst & ((state_r == FETCH) | (state_r == DISCARD));
  assign imem.imem_address = pc_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // PC, parked-instruction buffer, pending redirect target and IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      hold_buf_r <= 32'h0000_0000;
      redir_pc_r <= 32'h0000_0000;
      ifid_valid <= 1'b0;
      ifid_pc    <= 32'h0000_0000;
      ifid_instr <= NOP_INSTR;
    end else begin
      pc_r       <= pc_nxt_s;
      hold_buf_r <= hold_buf_nxt_s;
      redir_pc_r <= redir_pc_nxt_s;
      ifid_valid <= ifid_valid_nxt_s;
      ifid_pc    <= ifid_pc_nxt_s;
      ifid_instr <= ifid_instr_nxt_s;
    end
  end

  // Next-state and datapath decisions; a redirect always wins over stall
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    hold_buf_nxt_s   = hold_buf_r;
    redir_pc_nxt_s   = redir_pc_r;
    ifid_valid_nxt_s = ifid_valid;
    ifid_pc_nxt_s    = ifid_pc;
    ifid_instr_nxt_s = ifid_instr;

    case (state_r)
      FETCH: begin
        if (imem.imem_resp) begin
          if (redirect_s) begin
            pc_nxt_s         = alu_out;
            ifid_valid_nxt_s = 1'b0;
          end else if (!stall) begin
            ifid_valid_nxt_s = 1'b1;
            ifid_pc_nxt_s    = pc_r;
            ifid_instr_nxt_s = imem.imem_rdata;
            pc_nxt_s         = pc_r + 32'd4;
          end else begin
            hold_buf_nxt_s = imem.imem_rdata;
            state_nxt_s    = HOLD;
          end
        end else begin
          if (redirect_s) begin
            redir_pc_nxt_s   = alu_out;
            ifid_valid_nxt_s = 1'b0;
            state_nxt_s      = DISCARD;
          end else if (!stall) begin
            ifid_valid_nxt_s = 1'b0;
          end else begin
            ifid_valid_nxt_s = ifid_valid;
          end
        end
      end

      HOLD: begin
        if (redirect_s) begin
          pc_nxt_s         = alu_out;
          ifid_valid_nxt_s = 1'b0;
          state_nxt_s      = FETCH;
        end else if (!stall) begin
          ifid_valid_nxt_s = 1'b1;
          ifid_pc_nxt_s    = pc_r;
          ifid_instr_nxt_s = hold_buf_r;
          pc_nxt_s         = pc_r + 32'd4;
          state_nxt_s      = FETCH;
        end else begin
          state_nxt_s = HOLD;
        end
      end

      DISCARD: begin
        // The wrong-path read cannot be cancelled; wait for it and steer to the latest target.
        if (redirect_s) begin
          redir_pc_nxt_s   = alu_out;
          ifid_valid_nxt_s = 1'b0;
        end else if (!stall) begin
          ifid_valid_nxt_s = 1'b0;
        end else begin
          ifid_valid_nxt_s = ifid_valid;
        end
        if (imem.imem_resp) begin
          pc_nxt_s    = redirect_s ? alu_out : redir_pc_r;
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = DISCARD;
        end
      end

      default: begin
        state_nxt_s      = FETCH;
        ifid_valid_nxt_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcmux_sel;
  logic [31:0] alu_out;
  logic        stall;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .pcmux_sel  (pcmux_sel),
    .alu_out    (alu_out),
    .stall      (stall),
    .imem       (bus),
    .ifid_valid (ifid_valid),
    .ifid_pc    (ifid_pc),
    .ifid_instr (ifid_instr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ a[15:0]};
  endfunction

  // Behavioural model: program counter, a word parked by stall, and a
  // wrong-path read still in flight whose data must be thrown away.
  bit          started = 1'b0;
  logic [31:0] m_pc = 32'h0;
  bit          m_held = 1'b0;
  logic [31:0] m_held_word = 32'h0;
  bit          m_wrong_path = 1'b0;
  logic [31:0] m_wrong_target = 32'h0;
  bit          m_valid = 1'b0;
  logic [31:0] m_ifpc = 32'h0;
  logic [31:0] m_ifinstr = 32'h13;

  // Inputs seen during the cycle that ends at the next rising edge
  bit          p_rst = 1'b1;
  bit          p_sel = 1'b0;
  bit          p_st = 1'b0;
  bit          p_resp = 1'b0;
  logic [31:0] p_tgt = 32'h0;
  logic [31:0] p_rdata = 32'h0;

  // Memory responder state
  bit          busy = 1'b0;
  int          wait_left = 0;
  bit          rand_mode = 1'b0;

  task automatic deliver(input logic [31:0] word);
    m_valid   = 1'b1;
    m_ifpc    = m_pc;
    m_ifinstr = word;
    m_pc      = m_pc + 32'd4;
  endtask

  task automatic model_step();
    if (p_rst) begin
      m_pc = 32'h60; m_held = 1'b0; m_wrong_path = 1'b0;
      m_valid = 1'b0; m_ifpc = 32'h0; m_ifinstr = 32'h13;
    end else if (m_held) begin
      if (p_sel) begin
        m_pc = p_tgt; m_held = 1'b0; m_valid = 1'b0;
      end else if (!p_st) begin
        deliver(m_held_word); m_held = 1'b0;
      end
    end else if (m_wrong_path) begin
      if (p_sel) m_wrong_target = p_tgt;
      if (p_resp) begin
        m_pc = m_wrong_target; m_wrong_path = 1'b0;
      end
      if (p_sel || !p_st) m_valid = 1'b0;
    end else if (p_sel) begin
      m_valid = 1'b0;
      if (p_resp) m_pc = p_tgt;
      else begin
        m_wrong_path = 1'b1; m_wrong_target = p_tgt;
      end
    end else if (p_resp) begin
      if (p_st) begin
        m_held = 1'b1; m_held_word = p_rdata;
      end else begin
        deliver(p_rdata);
      end
    end else if (!p_st) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock cycle: advance model, drive inputs, then act as the memory.
  task automatic step(input bit r, input bit sel, input logic [31:0] tgt, input bit st, input int w);
    @(posedge clk);
    model_step();
    started = 1'b1;
    #1;
    rst = r; pcmux_sel = sel; alu_out = tgt; stall = st;
    #1;
    if (bus.imem_read) begin
      if (!busy) begin
        busy = 1'b1; wait_left = w;
      end
      if (wait_left == 0) begin
        bus.imem_resp = 1'b1; bus.imem_rdata = mem_word(bus.imem_address); busy = 1'b0;
      end else begin
        bus.imem_resp = 1'b0; bus.imem_rdata = $urandom; wait_left--;
      end
    end else begin
      busy = 1'b0;
      bus.imem_resp = rand_mode && ($urandom_range(0, 7) == 0);
      bus.imem_rdata = $urandom;
    end
    p_rst = r; p_sel = sel; p_tgt = tgt; p_st = st;
    p_resp = bus.imem_resp; p_rdata = bus.imem_rdata;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 0);
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      check("imem_read", {31'd0, bus.imem_read}, {31'd0, (!rst && !m_held)});
      check("imem_address", bus.imem_address, m_pc);
      check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      check("ifid_pc", ifid_pc, m_ifpc);
      check("ifid_instr", ifid_instr, m_ifinstr);
    end
  end

  initial begin
    rst = 1'b1; pcmux_sel = 1'b0; alu_out = 32'h0; stall = 1'b0;
    bus.imem_resp = 1'b0; bus.imem_rdata = 32'h0;

    // Zero-wait streaming
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check("t1_read", {31'd0, bus.imem_read}, 32'd1);
    check("t1_addr0", bus.imem_address, 32'h60);
    check("t1_valid0", {31'd0, ifid_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check("t1_addr1", bus.imem_address, 32'h64);
    check("t1_ifpc1", ifid_pc, 32'h60);
    check("t1_instr1", ifid_instr, mem_word(32'h60));
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check("t1_addr2", bus.imem_address, 32'h68);
    check("t1_ifpc2", ifid_pc, 32'h64);

    // Three-cycle memory latency
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 2);
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check("t2_addr_wait", bus.imem_address, 32'h60);
    check("t2_bubble1", {31'd0, ifid_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check("t2_bubble2", {31'd0, ifid_valid}, 32'd0);
    check("t2_addr_held", bus.imem_address, 32'h60);
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check("t2_valid", {31'd0, ifid_valid}, 32'd1);
    check("t2_ifpc", ifid_pc, 32'h60);

    // Stall as data arrives parks the word
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 0);
    check("t3_hold_read", {31'd0, bus.imem_read}, 32'd0);
    check("t3_hold_ifpc", ifid_pc, 32'h60);
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check("t3_ifpc", ifid_pc, 32'h64);
    check("t3_instr", ifid_instr, mem_word(32'h64));
    check("t3_addr", bus.imem_address, 32'h68);

    // Redirect while a read is pending
    do_reset();
    run(4);
    step(1'b0, 1'b1, 32'h200, 1'b0, 2);
    check("t4_addr_pend", bus.imem_address, 32'h70);
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check("t4_addr_hold", bus.imem_address, 32'h70);
    check("t4_flush", {31'd0, ifid_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check("t4_target", bus.imem_address, 32'h200);
    check("t4_valid", {31'd0, ifid_valid}, 32'd0);

    // Redirect with resp and stall together
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    step(1'b0, 1'b1, 32'h300, 1'b1, 0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check("t5_addr", bus.imem_address, 32'h300);
    check("t5_read", {31'd0, bus.imem_read}, 32'd1);
    check("t5_valid", {31'd0, ifid_valid}, 32'd0);

    // Reset while parked in HOLD
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 0);
    check("t6_rst_read", {31'd0, bus.imem_read}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check("t6_valid", {31'd0, ifid_valid}, 32'd0);
    check("t6_instr", ifid_instr, 32'h13);
    check("t6_addr", bus.imem_address, 32'h60);

    // PC wraps past the top of the address space
    do_reset();
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check("wrap_top", bus.imem_address, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    check("wrap_zero", bus.imem_address, 32'h0);
    check("wrap_ifpc", ifid_pc, 32'hFFFF_FFFC);

    // Randomized traffic with stray responses
    rand_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] tgt;
      int          w;
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      w   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0, tgt,
           $urandom_range(0, 2) == 0, w);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
